// File: rtl/depth_test_unit.sv
// depth_test_unit: per-fragment depth test against a word-addressed depth buffer, plus a buffer clear engine.
module depth_test_unit #(
    parameter int Z_SIZE       = 16,
    parameter int X_RES        = 640,
    parameter int Y_RES        = 480,
    parameter int X_PIXEL_SIZE = $clog2(X_RES),
    parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter int ADDR_SIZE    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [2:0]              depth_func_i,
    input  logic                    depth_write_en_i,
    input  logic [ADDR_SIZE-1:0]    buffer_base_address_i,
    input  logic [Z_SIZE-1:0]       clear_value_i,
    input  logic                    clear_i,
    output logic                    clear_busy_o,
    output logic                    clear_done_o,
    output logic                    mem_rd_req_valid_o,
    input  logic                    mem_rd_req_ready_i,
    output logic [ADDR_SIZE-1:0]    mem_addr_o,
    input  logic                    mem_rd_valid_i,
    input  logic [Z_SIZE-1:0]       mem_rd_data_i,
    output logic                    mem_wr_valid_o,
    input  logic                    mem_wr_ready_i,
    output logic [Z_SIZE-1:0]       mem_wr_data_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic                    res_pass_o,
    output logic [X_PIXEL_SIZE-1:0] res_x_o,
    output logic [Y_PIXEL_SIZE-1:0] res_y_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] RESULT  = 3'd4;
    localparam logic [2:0] CLEAR   = 3'd5;
    localparam logic [2:0] F_NEVER  = 3'd0;
    localparam logic [2:0] F_ALWAYS = 3'd7;
    localparam logic [X_PIXEL_SIZE:0] X_LIM    = (X_PIXEL_SIZE + 1)'(X_RES);
    localparam logic [Y_PIXEL_SIZE:0] Y_LIM    = (Y_PIXEL_SIZE + 1)'(Y_RES);
    localparam logic [ADDR_SIZE-1:0]  X_RES_A  = ADDR_SIZE'(X_RES);
    localparam logic [ADDR_SIZE-1:0]  LAST_PIX = ADDR_SIZE'(X_RES * Y_RES - 1);

    logic [2:0]              state_q, state_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [ADDR_SIZE-1:0]    cnt_q, cnt_d;
    logic [X_PIXEL_SIZE-1:0] x_q, x_d;
    logic [Y_PIXEL_SIZE-1:0] y_q, y_d;
    logic [Z_SIZE-1:0]       data_q, data_d;
    logic [2:0]              func_q, func_d;
    logic                    we_q, we_d, pass_q, pass_d, done_q, done_d;
    logic                    in_range, cmp_pass;
    logic [7:0]              cmp_vec;
    logic [ADDR_SIZE-1:0]    frag_addr;

    // data_q carries the fragment z during a test and the clear value during a clear
    assign in_range  = ({1'b0, frag_x_i} < X_LIM) && ({1'b0, frag_y_i} < Y_LIM);
    assign frag_addr = buffer_base_address_i + ADDR_SIZE'(frag_y_i) * X_RES_A + ADDR_SIZE'(frag_x_i);
    assign cmp_vec   = {1'b1, data_q != mem_rd_data_i, data_q == mem_rd_data_i, data_q >= mem_rd_data_i,
                        data_q > mem_rd_data_i, data_q <= mem_rd_data_i, data_q < mem_rd_data_i, 1'b0};
    assign cmp_pass  = cmp_vec[func_q];

    // Next-state logic: fragment test sequencing and clear address walk
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        func_d  = func_q;
        we_d    = we_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    addr_d  = buffer_base_address_i;
                    data_d  = clear_value_i;
                    cnt_d   = '0;
                end else if (frag_valid_i) begin
                    x_d    = frag_x_i;
                    y_d    = frag_y_i;
                    data_d = frag_z_i;
                    func_d = depth_func_i;
                    we_d   = depth_write_en_i;
                    addr_d = frag_addr;
                    if (!in_range || depth_func_i == F_NEVER) begin
                        pass_d  = 1'b0;
                        state_d = RESULT;
                    end else if (depth_func_i == F_ALWAYS) begin
                        pass_d  = 1'b1;
                        state_d = depth_write_en_i ? WR : RESULT;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_d = mem_rd_req_ready_i ? RD_WAIT : RD_REQ;
            RD_WAIT: begin
                if (mem_rd_valid_i) begin
                    pass_d  = cmp_pass;
                    state_d = (cmp_pass && we_q) ? WR : RESULT;
                end
            end
            WR:      state_d = mem_wr_ready_i ? RESULT : WR;
            RESULT:  state_d = res_ready_i ? IDLE : RESULT;
            CLEAR: begin
                if (mem_wr_ready_i) begin
                    if (cnt_q == LAST_PIX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any operation in progress
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            func_q  <= '0;
            we_q    <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            func_q  <= func_d;
            we_q    <= we_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first reset edge
    assign frag_ready_o       = rst_ni && state_q == IDLE && !clear_i;
    assign mem_rd_req_valid_o = rst_ni && state_q == RD_REQ;
    assign mem_wr_valid_o     = rst_ni && (state_q == WR || state_q == CLEAR);
    assign mem_addr_o         = rst_ni ? addr_q : '0;
    assign mem_wr_data_o      = rst_ni ? data_q : '0;
    assign res_valid_o        = rst_ni && state_q == RESULT;
    assign res_pass_o         = rst_ni && pass_q;
    assign res_x_o            = rst_ni ? x_q : '0;
    assign res_y_o            = rst_ni ? y_q : '0;
    assign clear_busy_o       = rst_ni && state_q == CLEAR;
    assign clear_done_o       = rst_ni && done_q;
endmodule

// File: doc/depth_test_unit.md
DEPTH_TEST_UNIT -- requirements
Module: depth_test_unit

Interface
REQ-001 SHALL have parameter Z_SIZE, default 16, depth word width in bits.
REQ-002 SHALL have parameter X_RES, default 640, horizontal resolution in pixels.
REQ-003 SHALL have parameter Y_RES, default 480, vertical resolution in pixels.
REQ-004 SHALL have parameters X_PIXEL_SIZE = $clog2(X_RES), Y_PIXEL_SIZE = $clog2(Y_RES), and ADDR_SIZE (default 32, word address width).
REQ-005 SHALL have ports clk_i in 1, the single clock, and rst_ni in 1, a synchronous active-low reset.
REQ-006 SHALL have ports frag_valid_i in 1, frag_ready_o out 1, frag_x_i in X_PIXEL_SIZE, frag_y_i in Y_PIXEL_SIZE, and frag_z_i in Z_SIZE, forming the fragment stream.
REQ-007 SHALL have config ports depth_func_i in 3, depth_write_en_i in 1, buffer_base_address_i in ADDR_SIZE, and clear_value_i in Z_SIZE.
REQ-008 SHALL have port clear_i in 1, a clear request pulse, and outputs clear_busy_o out 1 and clear_done_o out 1.
REQ-009 SHALL have read-request ports mem_rd_req_valid_o out 1, mem_rd_req_ready_i in 1, and mem_addr_o out ADDR_SIZE (the shared read/write word address).
REQ-010 SHALL have read-response ports mem_rd_valid_i in 1 and mem_rd_data_i in Z_SIZE.
REQ-011 SHALL have write ports mem_wr_valid_o out 1, mem_wr_ready_i in 1, and mem_wr_data_o out Z_SIZE.
REQ-012 SHALL have result ports res_valid_o out 1, res_ready_i in 1, res_pass_o out 1, res_x_o out X_PIXEL_SIZE, and res_y_o out Y_PIXEL_SIZE.

Function
REQ-013 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR, RESULT, CLEAR, one fragment in flight.
REQ-014 SHALL assert frag_ready_o only in IDLE with clear_i low; acceptance = frag_valid_i && frag_ready_o.
REQ-015 SHALL latch x, y, z, depth_func_i, depth_write_en_i, and the computed address at acceptance; later config changes SHALL not affect that fragment.
REQ-016 SHALL compute the address as buffer_base_address_i + y*X_RES + x, zero-extended to ADDR_SIZE, with wrap-around modulo 2^ADDR_SIZE.
REQ-017 SHALL use function codes 0 NEVER, 1 LESS, 2 LEQUAL, 3 GREATER, 4 GEQUAL, 5 EQUAL, 6 NOTEQUAL, 7 ALWAYS; comparisons are unsigned, of the fragment z against the stored z.
REQ-018 SHALL, for codes 1-6: IDLE->RD_REQ; hold mem_rd_req_valid_o=1 until mem_rd_req_ready_i; then RD_WAIT until mem_rd_valid_i, where the compare uses mem_rd_data_i that same cycle.
REQ-019 SHALL, for NEVER/ALWAYS, issue no read and decide pass in the cycle after acceptance.
REQ-020 SHALL treat out-of-range fragments (x>=X_RES or y>=Y_RES) as fail, with no memory access.
REQ-021 SHALL, on pass with the latched write enable=1, enter WR: mem_wr_valid_o=1, mem_wr_data_o=z, mem_addr_o=address, held until mem_wr_ready_i, then RESULT.
REQ-022 SHALL, otherwise, go straight to RESULT.
REQ-023 SHALL hold res_valid_o with stable res_pass_o/res_x_o/res_y_o until res_ready_i, then return to IDLE.
REQ-024 SHALL hold mem_addr_o stable while any mem valid is high.
REQ-025 SHALL, on clear_i in IDLE, enter CLEAR; clear_i SHALL take priority over a simultaneous frag_valid_i; clear_i outside IDLE SHALL be ignored.
REQ-026 SHALL, in CLEAR, write clear_value_i (latched at entry) to base..base+X_RES*Y_RES-1, one word per mem_wr_ready_i handshake, with an internal counter.
REQ-027 SHALL keep clear_busy_o=1 throughout CLEAR.
REQ-028 SHALL, after the final handshake, pulse clear_done_o for exactly one cycle and return to IDLE.
REQ-029 SHALL never assert mem_rd_req_valid_o and mem_wr_valid_o in the same cycle.

Reset
REQ-030 SHALL, with rst_ni=0 at a clock edge, enter IDLE from any state, including mid-CLEAR or mid-handshake, abandoning the operation.
REQ-031 SHALL drive all valid outputs, res_pass_o, clear_busy_o, clear_done_o, mem_addr_o, mem_wr_data_o, res_x_o, and res_y_o to 0 during reset.
REQ-032 SHALL drive frag_ready_o to 0 while rst_ni=0.

Verification (Z_SIZE=8, X_RES=4, Y_RES=4, base=0x100)
REQ-033 SHALL cover: LESS, frag (1,2,z=0x10), mem returns 0x20, write_en=1 -> read addr 0x109; write 0x10 to 0x109; res_pass_o=1, x=1, y=2.
REQ-034 SHALL cover: GEQUAL, z=0x10, mem returns 0x20 -> res_pass_o=0; no write issued.
REQ-035 SHALL cover: ALWAYS with write_en=0 -> no read, no write; res_valid_o one cycle after acceptance, pass=1.
REQ-036 SHALL cover: clear_i with clear_value_i=0xFF, mem_wr_ready_i toggling -> 16 writes of 0xFF to 0x100..0x10F in order; one clear_done_o pulse; frag_ready_o=0 throughout.
REQ-037 SHALL cover: res_ready_i held low 5 cycles -> res_* stable; frag_ready_o=0; then completion.
REQ-038 SHALL cover: rst_ni low during the 7th clear write -> all outputs 0 next cycle; IDLE; a subsequent fragment processes normally.
